// File: rtl/iterative_shifter.sv
// Multi-cycle barrel-shifter replacement: one bit position per clock for LSL/LSR/ASR/ROR,
// with a one-cycle result pulse, sticky LSL overflow, abort via Module_Enable and synchronous reset.
module iterative_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 8
) (
    input  logic               Main_CLK,
    input  logic               Main_RST,
    input  logic               Module_Enable,
    input  logic               Start_In,
    input  logic [1:0]         Mode,
    input  logic [DATA_W-1:0]  InputToShift,
    input  logic [SHAMT_W-1:0] ShiftNumber,
    output logic [DATA_W-1:0]  ShiftedOutput,
    output logic               Valid_Output,
    output logic               Busy,
    output logic               Overflow,
    output logic [1:0]         fsm_state
);

    localparam int LOG_W = $clog2(DATA_W);
    localparam int CNT_W = LOG_W + 1;
    localparam int EXT_W = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t            state;
    state_t            next_state;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  eff_n;
    logic [EXT_W-1:0]  amt_ext;
    logic [DATA_W-1:0] step_val;
    logic              accept;
    logic              do_shift;

    // Handshake: an operation is accepted on a rising edge where state is IDLE and
    // Module_Enable and Start_In are both high; Valid_Output pulses for the single
    // DONE cycle, and Start_In is ignored whenever Busy is high.
    assign amt_ext   = EXT_W'(ShiftNumber);
    assign fsm_state = state;

    // Rotation wraps modulo the width; linear shifts saturate at the full width.
    always_comb begin
        eff_n = '0;
        if (Mode == MODE_ROR) begin
            eff_n = {{(CNT_W-LOG_W){1'b0}}, amt_ext[LOG_W-1:0]};
        end else if (amt_ext >= EXT_W'(DATA_W)) begin
            eff_n = CNT_W'(DATA_W);
        end else begin
            eff_n = amt_ext[CNT_W-1:0];
        end
    end

    always_comb begin
        step_val = ShiftedOutput;
        case (mode_r)
            MODE_LSL: step_val = {ShiftedOutput[DATA_W-2:0], 1'b0};
            MODE_LSR: step_val = {1'b0, ShiftedOutput[DATA_W-1:1]};
            MODE_ASR: step_val = {ShiftedOutput[DATA_W-1], ShiftedOutput[DATA_W-1:1]};
            default:  step_val = {ShiftedOutput[0], ShiftedOutput[DATA_W-1:1]};
        endcase
    end

    // State register; Busy and Valid_Output are registered from the next state.
    always_ff @(posedge Main_CLK) begin
        if (Main_RST) begin
            state        <= IDLE;
            Busy         <= 1'b0;
            Valid_Output <= 1'b0;
        end else begin
            state        <= next_state;
            Busy         <= (next_state != IDLE);
            Valid_Output <= (next_state == DONE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (eff_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (!Module_Enable) begin
                    next_state = IDLE;
                end else if (count == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        do_shift = 1'b0;
        case (state)
            IDLE:    accept   = Module_Enable && Start_In;
            SHIFT:   do_shift = Module_Enable;
            default: begin
                accept   = 1'b0;
                do_shift = 1'b0;
            end
        endcase
    end

    // Working register doubles as the visible result and holds after DONE or an abort.
    always_ff @(posedge Main_CLK) begin
        if (Main_RST) begin
            ShiftedOutput <= '0;
            Overflow      <= 1'b0;
            count         <= '0;
            mode_r        <= MODE_LSL;
        end else if (accept) begin
            ShiftedOutput <= InputToShift;
            Overflow      <= 1'b0;
            count         <= eff_n;
            mode_r        <= Mode;
        end else if (do_shift) begin
            ShiftedOutput <= step_val;
            count         <= count - CNT_W'(1);
            if (mode_r == MODE_LSL && ShiftedOutput[DATA_W-1]) begin
                Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter (DATA_W=32): directed vectors, randomized operations
// against an arithmetic reference model, busy-ignore, abort and mid-operation reset.
module tb_iterative_shifter;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam int TIMEOUT = 80;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [7:0]  amt;
    logic [31:0] dout;
    logic        valid;
    logic        busy;
    logic        ovf;
    logic [1:0]  fsm_state;

    int errors;
    int checks;

    iterative_shifter #(.DATA_W(32), .SHAMT_W(8)) dut (
        .Main_CLK      (clk),
        .Main_RST      (rst),
        .Module_Enable (en),
        .Start_In      (start),
        .Mode          (mode),
        .InputToShift  (din),
        .ShiftNumber   (amt),
        .ShiftedOutput (dout),
        .Valid_Output  (valid),
        .Busy          (busy),
        .Overflow      (ovf),
        .fsm_state     (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-operation result from plain shift arithmetic.
    function automatic void ref_model(input logic [1:0] m, input logic [31:0] d,
                                      input logic [7:0] a, output logic [31:0] r,
                                      output logic o, output int n);
        logic [63:0] w;
        int          amount;
        amount = int'(a);
        n = (m == ROR) ? (amount % 32) : ((amount > 32) ? 32 : amount);
        o = 1'b0;
        r = d;
        case (m)
            LSL: begin
                w = {32'b0, d} << n;
                r = w[31:0];
                o = (w[63:32] != 32'b0);
            end
            LSR: r = d >> n;
            ASR: r = 32'($signed(d) >>> n);
            default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    // Issues one operation from IDLE and follows it through DONE and back to IDLE.
    // glitch > 0 re-pulses Start_In so that it is sampled at edge k+glitch.
    task automatic run_op(input logic [1:0] m, input logic [31:0] d, input logic [7:0] a,
                          input int glitch, input string name);
        logic [31:0] exp_r;
        logic        exp_o;
        int          exp_n;
        int          cycles;
        ref_model(m, d, a, exp_r, exp_o, exp_n);
        start = 1'b1;
        mode  = m;
        din   = d;
        amt   = a;
        tick();
        start  = 1'b0;
        mode   = 2'($urandom);
        din    = $urandom;
        amt    = 8'($urandom);
        cycles = 0;
        while (valid !== 1'b1 && cycles < TIMEOUT) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_shift: cycle %0d busy=%b expected 1", name, cycles, busy);
            end
            start = (glitch > 0 && cycles == glitch - 1) ? 1'b1 : 1'b0;
            if (start) begin
                din = $urandom;
                amt = 8'($urandom_range(1, 5));
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (cycles !== exp_n) begin
            errors++;
            $display("FAIL %s latency: valid after %0d edges, expected %0d", name, cycles, exp_n);
        end
        checks++;
        if (dout !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, dout, exp_r);
        end
        checks++;
        if (ovf !== exp_o) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, ovf, exp_o);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_done: got %b expected 1", name, busy);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || dout !== exp_r || ovf !== exp_o) begin
            errors++;
            $display("FAIL %s after_done: valid=%b busy=%b out=%h ovf=%b expected 0 0 %h %b",
                     name, valid, busy, dout, ovf, exp_r, exp_o);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode = 2'($urandom);
            din  = $urandom;
            amt  = 8'($urandom);
            tick();
            checks++;
            if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: out=%h valid=%b busy=%b ovf=%b expected all 0",
                         dout, valid, busy, ovf);
            end
        end
        rst = 1'b0;
        // First edge with reset low must accept.
        run_op(LSL, 32'h0000_00A5, 8'd4, 0, "lsl_a5_by4");
    endtask

    task automatic test_directed();
        run_op(ASR, 32'h8000_0000, 8'd40, 0, "asr_by40");
        run_op(LSR, 32'h8000_0000, 8'd40, 0, "lsr_by40");
        run_op(ROR, 32'h0000_0001, 8'd33, 0, "ror_by33");
        run_op(ROR, 32'h0000_0001, 8'd32, 0, "ror_by32");
        run_op(LSL, 32'hC000_0000, 8'd1, 0, "lsl_ovf");
        run_op(LSR, 32'hC000_0000, 8'd1, 0, "lsr_clears_ovf");
        run_op(LSL, 32'hFFFF_FFFF, 8'd32, 0, "lsl_full");
        run_op(ASR, 32'h7FFF_FFFF, 8'd255, 0, "asr_pos_sat");
        run_op(LSL, 32'h0000_FFFF, 8'd0, 0, "lsl_zero");
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 2));
                1: a = 8'($urandom_range(30, 34));
                2: a = 8'($urandom_range(62, 66));
                default: a = 8'($urandom);
            endcase
            run_op(2'($urandom), $urandom, a, 0, "random");
        end
    endtask

    task automatic test_busy_ignore();
        run_op(LSR, 32'h0000_00FF, 8'd8, 3, "busy_ignore");
        run_op(LSL, 32'h1234_5678, 8'd2, 1, "busy_ignore_short");
    endtask

    task automatic test_abort();
        start = 1'b1;
        mode  = LSR;
        din   = 32'h0000_00FF;
        amt   = 8'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || dout !== 32'h0000_001F || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b out=%h ovf=%b expected 0 0 0000001f 0",
                     busy, valid, dout, ovf);
        end
        // Disabled while idle: Start_In must not be accepted and the output holds.
        start = 1'b1;
        din   = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || dout !== 32'h0000_001F) begin
                errors++;
                $display("FAIL disabled_hold: busy=%b valid=%b out=%h expected 0 0 0000001f",
                         busy, valid, dout);
            end
        end
        en = 1'b1;
        run_op(ROR, 32'hA5A5_0F0F, 8'd7, 0, "after_abort");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        mode  = LSL;
        din   = 32'hFFFF_FFFF;
        amt   = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ovf !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_progress: ovf=%b busy=%b expected 1 1", ovf, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out=%h valid=%b busy=%b ovf=%b expected all 0",
                     dout, valid, busy, ovf);
        end
        run_op(LSL, 32'h0000_0003, 8'd10, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(LSR, 32'hDEAD_BEEF, 8'd3, 0, "b2b_0");
        run_op(ASR, 32'hDEAD_BEEF, 8'd0, 0, "b2b_1");
        run_op(ROR, 32'hDEAD_BEEF, 8'd31, 0, "b2b_2");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        en     = 1'b0;
        start  = 1'b0;
        mode   = LSL;
        din    = '0;
        amt    = '0;
        tick();
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
